ex_wb_pipe: RTL and testbench

//  Parametrised elastic result pipe between the EX functional units and WB/ROB.

---
 rtl/ex_wb_pipe.sv | 144 ++++++++++++++
 tb/tb_ex_wb_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_pipe.sv
// Elastic EX->WB result pipe of CONFIG_EX_STAGES valid/ready stages with collapsing bubbles,
// global flush and occupancy count. Optional forwarding taps: define NCPU_EX_WB_PIPE_FWD_EN.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module ex_wb_pipe #(
    parameter int unsigned CONFIG_DW             = 64,
    parameter int unsigned CONFIG_AW             = 64,
    parameter int unsigned CONFIG_P_ROB_DEPTH    = 4,
    parameter int unsigned CONFIG_P_COMMIT_WIDTH = 1,
    parameter int unsigned CONFIG_EX_STAGES      = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    ex_valid,
    output logic                                    ex_ready,
    input  logic                                    ex_prf_we,
    input  logic [`NCPU_PRF_AW-1:0]                 ex_prd,
    input  logic [CONFIG_DW-1:0]                    ex_wdata,
    input  logic [CONFIG_P_ROB_DEPTH-1:0]           ex_rob_id,
    input  logic [CONFIG_P_COMMIT_WIDTH-1:0]        ex_rob_bank,
    input  logic                                    ex_fls,
    input  logic                                    ex_exc,
    input  logic [CONFIG_AW-1:0]                    ex_opera,
    input  logic [CONFIG_DW-1:0]                    ex_operb,
    output logic                                    wb_valid,
    input  logic                                    wb_ready,
    output logic [CONFIG_P_ROB_DEPTH-1:0]           wb_rob_id,
    output logic [CONFIG_P_COMMIT_WIDTH-1:0]        wb_rob_bank,
    output logic [`NCPU_PRF_AW-1:0]                 prf_WADDR,
    output logic [CONFIG_DW-1:0]                    prf_WDATA,
    output logic [CONFIG_AW-1:0]                    wb_opera,
    output logic [CONFIG_DW-1:0]                    wb_operb,
    output logic                                    prf_WE,
    output logic                                    wb_fls,
    output logic                                    wb_exc,
    output logic [$clog2(CONFIG_EX_STAGES+1)-1:0]   occ_cnt
`ifdef NCPU_EX_WB_PIPE_FWD_EN
    ,
    output logic [CONFIG_EX_STAGES-1:0]             fwd_valid,
    output logic [CONFIG_EX_STAGES*`NCPU_PRF_AW-1:0] fwd_prd,
    output logic [CONFIG_EX_STAGES*CONFIG_DW-1:0]   fwd_wdata
`endif
);

    localparam int unsigned N   = CONFIG_EX_STAGES;
    localparam int unsigned PAW = `NCPU_PRF_AW;
    localparam int unsigned CW  = $clog2(CONFIG_EX_STAGES + 1);

    logic [N-1:0]                     v_q;
    logic [N-1:0]                     ce;
    logic                             tail_full;
    logic [N-1:0]                     we_q;
    logic [N-1:0]                     fls_q;
    logic [N-1:0]                     exc_q;
    logic [PAW-1:0]                   prd_q   [N];
    logic [CONFIG_DW-1:0]             wdata_q [N];
    logic [CONFIG_P_ROB_DEPTH-1:0]    rid_q   [N];
    logic [CONFIG_P_COMMIT_WIDTH-1:0] bank_q  [N];
    logic [CONFIG_AW-1:0]             opera_q [N];
    logic [CONFIG_DW-1:0]             operb_q [N];
    logic [CW-1:0]                    occ_q;
    logic                             acc;
    logic                             ret;

    // A stage advances unless it and every stage ahead of it are full while WB stalls.
    always_comb begin
        ce        = '0;
        tail_full = 1'b1;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            tail_full = tail_full & v_q[k];
            ce[k]     = wb_ready | ~tail_full;
        end
    end

    assign ex_ready = ce[0];
    assign acc      = ex_valid & ex_ready;
    assign ret      = wb_valid & wb_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            if (ce[0]) v_q[0] <= ex_valid;
            for (int unsigned k = 1; k < N; k++) begin
                if (ce[k]) v_q[k] <= v_q[k-1];
            end
            if (acc && !ret) occ_q <= occ_q + CW'(1);
            else if (ret && !acc) occ_q <= occ_q - CW'(1);
        end
    end

    // Payload carries no reset; it is qualified by the stage valid.
    always_ff @(posedge clk) begin
        if (ce[0]) begin
            we_q[0]    <= ex_prf_we;
            fls_q[0]   <= ex_fls;
            exc_q[0]   <= ex_exc;
            prd_q[0]   <= ex_prd;
            wdata_q[0] <= ex_wdata;
            rid_q[0]   <= ex_rob_id;
            bank_q[0]  <= ex_rob_bank;
            opera_q[0] <= ex_opera;
            operb_q[0] <= ex_operb;
        end
        for (int unsigned k = 1; k < N; k++) begin
            if (ce[k]) begin
                we_q[k]    <= we_q[k-1];
                fls_q[k]   <= fls_q[k-1];
                exc_q[k]   <= exc_q[k-1];
                prd_q[k]   <= prd_q[k-1];
                wdata_q[k] <= wdata_q[k-1];
                rid_q[k]   <= rid_q[k-1];
                bank_q[k]  <= bank_q[k-1];
                opera_q[k] <= opera_q[k-1];
                operb_q[k] <= operb_q[k-1];
            end
        end
    end

    assign wb_valid    = v_q[N-1];
    assign prf_WE      = v_q[N-1] & we_q[N-1];
    assign wb_fls      = v_q[N-1] & fls_q[N-1];
    assign wb_exc      = v_q[N-1] & exc_q[N-1];
    assign wb_rob_id   = rid_q[N-1];
    assign wb_rob_bank = bank_q[N-1];
    assign prf_WADDR   = prd_q[N-1];
    assign prf_WDATA   = wdata_q[N-1];
    assign wb_opera    = opera_q[N-1];
    assign wb_operb    = operb_q[N-1];
    assign occ_cnt     = occ_q;

`ifdef NCPU_EX_WB_PIPE_FWD_EN
    for (genvar k = 0; k < int'(N); k++) begin : g_fwd
        assign fwd_valid[k]                         = v_q[k] & we_q[k];
        assign fwd_prd[k*PAW +: PAW]                = prd_q[k];
        assign fwd_wdata[k*CONFIG_DW +: CONFIG_DW]  = wdata_q[k];
    end
`endif

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Self-checking bench for ex_wb_pipe: directed scenarios plus random traffic against an
// in-order queue model that predicts WB arrival times from acceptance and departure cycles.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module tb_ex_wb_pipe;

    localparam int N   = 3;
    localparam int PAW = `NCPU_PRF_AW;
    localparam int CW  = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst, flush, ex_valid, ex_ready, ex_prf_we, ex_fls, ex_exc;
    logic [PAW-1:0] ex_prd, prf_WADDR;
    logic [63:0] ex_wdata, ex_opera, ex_operb, prf_WDATA, wb_opera, wb_operb;
    logic [3:0] ex_rob_id, wb_rob_id;
    logic [0:0] ex_rob_bank, wb_rob_bank;
    logic wb_valid, wb_ready, prf_WE, wb_fls, wb_exc;
    logic [CW-1:0] occ_cnt;
`ifdef NCPU_EX_WB_PIPE_FWD_EN
    logic [N-1:0] fwd_valid;
    logic [N*PAW-1:0] fwd_prd;
    logic [N*64-1:0] fwd_wdata;
`endif

    always #5 clk = ~clk;

    ex_wb_pipe #(.CONFIG_EX_STAGES(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_prf_we(ex_prf_we), .ex_prd(ex_prd),
        .ex_wdata(ex_wdata), .ex_rob_id(ex_rob_id), .ex_rob_bank(ex_rob_bank),
        .ex_fls(ex_fls), .ex_exc(ex_exc), .ex_opera(ex_opera), .ex_operb(ex_operb),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_id(wb_rob_id),
        .wb_rob_bank(wb_rob_bank), .prf_WADDR(prf_WADDR), .prf_WDATA(prf_WDATA),
        .wb_opera(wb_opera), .wb_operb(wb_operb), .prf_WE(prf_WE), .wb_fls(wb_fls),
        .wb_exc(wb_exc), .occ_cnt(occ_cnt)
`ifdef NCPU_EX_WB_PIPE_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_prd(fwd_prd), .fwd_wdata(fwd_wdata)
`endif
    );

    typedef struct {
        int             t;
        logic           we;
        logic [PAW-1:0] prd;
        logic [63:0]    wdata;
        logic [3:0]     rid;
        logic [0:0]     bank;
        logic           fls;
        logic           exc;
        logic [63:0]    opera;
        logic [63:0]    operb;
    } op_t;

    op_t q[$];
    int  cyc      = 0;
    int  last_dep = -100;
    bit  chk_en   = 0;
    int  n_cmp    = 0;
    int  n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic we, input logic [PAW-1:0] prd,
                          input logic [63:0] d, input logic fls, input logic [63:0] opa);
        ex_valid = v; ex_prf_we = we; ex_prd = prd; ex_wdata = d;
        ex_rob_id = d[3:0]; ex_rob_bank = d[4:4]; ex_fls = fls; ex_exc = d[5];
        ex_opera = opa; ex_operb = ~d;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        int   arr;
        logic er, ev, acc, dep;
        int   nwe;
        op_t  h;
        @(negedge clk);
        er = wb_ready | (q.size() < N);
        ev = 1'b0;
        if (q.size() > 0) begin
            h   = q[0];
            arr = (h.t + N > last_dep + 1) ? h.t + N : last_dep + 1;
            ev  = (cyc >= arr);
        end
        if (chk_en) begin
            chk("ex_ready", 64'(ex_ready), 64'(er));
            chk("wb_valid", 64'(wb_valid), 64'(ev));
            chk("occ_cnt", 64'(occ_cnt), 64'(q.size()));
            chk("prf_WE", 64'(prf_WE), 64'(ev & h.we));
            chk("wb_fls", 64'(wb_fls), 64'(ev & h.fls));
            chk("wb_exc", 64'(wb_exc), 64'(ev & h.exc));
            if (ev) begin
                chk("prf_WDATA", prf_WDATA, h.wdata);
                chk("prf_WADDR", 64'(prf_WADDR), 64'(h.prd));
                chk("wb_rob_id", 64'(wb_rob_id), 64'(h.rid));
                chk("wb_rob_bank", 64'(wb_rob_bank), 64'(h.bank));
                chk("wb_opera", wb_opera, h.opera);
                chk("wb_operb", wb_operb, h.operb);
            end
`ifdef NCPU_EX_WB_PIPE_FWD_EN
            nwe = 0;
            foreach (q[i]) nwe += int'(q[i].we);
            chk("fwd_count", 64'($countones(fwd_valid)), 64'(nwe));
`endif
        end
        acc = ex_valid & er;
        dep = ev & wb_ready;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            last_dep = -100;
            if (rst) chk_en = 1;
        end else begin
            if (dep) begin
                void'(q.pop_front());
                last_dep = cyc;
            end
            if (acc) q.push_back('{cyc, ex_prf_we, ex_prd, ex_wdata, ex_rob_id, ex_rob_bank,
                                   ex_fls, ex_exc, ex_opera, ex_operb});
        end
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; wb_ready = 1;
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        cycle(); cycle();
        rst = 0;
        cycle();

        // back-to-back stream, data 1..4
        for (int i = 1; i <= 4; i++) begin
            set_op(1, 1, PAW'(i), 64'(i), 0, 64'(i * 16));
            cycle();
        end
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        repeat (5) cycle();

        // fill with WB stalled, then release
        wb_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_op(1, 1, PAW'(i + 8), 64'(100 + i), 0, 64'(i));
            cycle();
        end
        wb_ready = 1;
        repeat (2) cycle();
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        repeat (5) cycle();

        // bubble collapse: ops at t0 and t2, stall from t3
        set_op(1, 1, 7'd3, 64'h33, 0, 64'd0); cycle();
        set_op(0, 0, '0, 64'd0, 0, 64'd0);    cycle();
        set_op(1, 0, 7'd4, 64'h44, 0, 64'd0); cycle();
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        wb_ready = 0;
        repeat (4) cycle();
        wb_ready = 1;
        repeat (4) cycle();

        // flush with two in flight and a same-cycle beat
        set_op(1, 1, 7'd1, 64'h51, 0, 64'd0); cycle();
        set_op(1, 1, 7'd2, 64'h52, 0, 64'd0); cycle();
        flush = 1;
        set_op(1, 1, 7'd3, 64'h53, 0, 64'd0); cycle();
        flush = 0;
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        repeat (5) cycle();

        // mispredict flush request carried with its target, with and without PRF write
        set_op(1, 1, 7'd9, 64'hAB, 1, 64'h1000); cycle();
        set_op(1, 0, 7'd9, 64'hAB, 1, 64'h1000); cycle();
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        repeat (5) cycle();

`ifdef NCPU_EX_WB_PIPE_FWD_EN
        set_op(1, 1, 7'd5, 64'hAA, 0, 64'd0); cycle();
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        chk("fwd_valid0", 64'(fwd_valid[0]), 64'd1);
        chk("fwd_prd0", 64'(fwd_prd[PAW-1:0]), 64'd5);
        chk("fwd_wdata0", fwd_wdata[63:0], 64'hAA);
        flush = 1; cycle(); flush = 0;
        chk("fwd_flushed", 64'(fwd_valid), 64'd0);
        repeat (2) cycle();
`endif

        // random traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 600; i++) begin
            set_op(1'($urandom_range(0, 3) != 0), 1'($urandom), PAW'($urandom),
                   {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0), {$urandom, $urandom});
            wb_ready = (i % 100 < 50) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 49) == 0);
            rst = (i == 300);
            cycle();
        end
        rst = 0; flush = 0;
        set_op(0, 0, '0, 64'd0, 0, 64'd0);
        wb_ready = 1;
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
